// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a big-endian byte stream (start PC, word count,
// words), writes each word to instruction memory, then releases the CPU from reset at the start PC.
module imem_loader #(
    parameter int unsigned MAX_WORDS   = 256,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        restart,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_Reset_L,
    output logic [31:0] cpu_startPC,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        StHdrPc,
        StHdrCnt,
        StData,
        StWrite,
        StHold,
        StRun,
        StErr
    } state_e;

    localparam logic [16:0] MaxWords = 17'(MAX_WORDS);
    localparam logic [31:0] HoldLast = 32'(HOLD_CYCLES - 1);

    state_e      state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] pc_q;
    logic [15:0] n_q;
    logic [23:0] shift_q;
    logic [31:0] hold_cnt_q;

    logic        xfer;
    logic [15:0] n_next;
    logic        hdr_bad;

    assign rx_ready = (state_q == StHdrPc) || (state_q == StHdrCnt) || (state_q == StData);
    assign xfer     = rx_valid && rx_ready;
    assign n_next   = {n_q[7:0], rx_data};
    assign hdr_bad  = (pc_q[1:0] != 2'b00) || (n_next == 16'd0) || ({1'b0, n_next} > MaxWords);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= StHdrPc;
            byte_cnt_q   <= 2'd0;
            pc_q         <= 32'd0;
            n_q          <= 16'd0;
            shift_q      <= 24'd0;
            hold_cnt_q   <= 32'd0;
            imem_we      <= 1'b0;
            imem_addr    <= 32'd0;
            imem_wdata   <= 32'd0;
            cpu_Reset_L  <= 1'b0;
            cpu_startPC  <= 32'd0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else if (restart) begin
            // Any byte presented on this edge is dropped along with the partial load.
            state_q      <= StHdrPc;
            byte_cnt_q   <= 2'd0;
            hold_cnt_q   <= 32'd0;
            imem_we      <= 1'b0;
            cpu_Reset_L  <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            case (state_q)
                StHdrPc: begin
                    if (xfer) begin
                        pc_q       <= {pc_q[23:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) state_q <= StHdrCnt;
                    end
                end
                StHdrCnt: begin
                    if (xfer) begin
                        n_q <= n_next;
                        if (byte_cnt_q == 2'd1) begin
                            byte_cnt_q <= 2'd0;
                            if (hdr_bad) begin
                                state_q <= StErr;
                                err     <= 1'b1;
                            end else begin
                                // Pre-decrement so every word, including the first, adds 4.
                                state_q      <= StData;
                                imem_addr    <= pc_q - 32'd4;
                                words_loaded <= 16'd0;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        shift_q    <= {shift_q[15:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            imem_wdata <= {shift_q, rx_data};
                            imem_addr  <= imem_addr + 32'd4;
                            imem_we    <= 1'b1;
                            state_q    <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (words_loaded < n_q) words_loaded <= words_loaded + 16'd1;
                    if (words_loaded + 16'd1 == n_q) begin
                        state_q     <= StHold;
                        cpu_startPC <= pc_q;
                        hold_cnt_q  <= 32'd0;
                    end else begin
                        state_q <= StData;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_q     <= StRun;
                        cpu_Reset_L <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 32'd1;
                    end
                end
                StRun, StErr: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= StHdrPc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: exact-timing hand sequences, a table of header cases,
// and randomized loads compared against a stream-level model of the expected writes.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned MAXW = 8;
    localparam int unsigned HOLD = 2;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        restart;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_Reset_L;
    logic [31:0] cpu_startPC;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    always #5 CLK = ~CLK;

    imem_loader #(
        .MAX_WORDS  (MAXW),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .restart     (restart),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_Reset_L (cpu_Reset_L),
        .cpu_startPC (cpu_startPC),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] stim_words[$];

    // Every write strobe seen, sampled mid-cycle; the loader must not accept bytes meanwhile.
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            wr_t w;
            w.addr = imem_addr;
            w.data = imem_wdata;
            wr_q.push_back(w);
            checks++;
            if (rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL rx_ready_during_write: got %b expected 0", rx_ready);
            end
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, ":rx_ready"}, rx_ready, 1'b1);
        chk1({tag, ":imem_we"}, imem_we, 1'b0);
        chk32({tag, ":imem_addr"}, imem_addr, 32'd0);
        chk32({tag, ":imem_wdata"}, imem_wdata, 32'd0);
        chk1({tag, ":cpu_Reset_L"}, cpu_Reset_L, 1'b0);
        chk32({tag, ":cpu_startPC"}, cpu_startPC, 32'd0);
        chk1({tag, ":done"}, done, 1'b0);
        chk1({tag, ":err"}, err, 1'b0);
        chk32({tag, ":words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    // gap: 0 = valid held high, 1 = one idle cycle before each byte, 2 = random 0..2 idles
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        int idle;
        waited = 0;
        idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < idle; i++) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) chk1("rx_ready_timeout", rx_ready, 1'b1);
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic send_header(input logic [31:0] pc, input logic [15:0] n, input int gap);
        send_word(pc, gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
    endtask

    task automatic do_restart();
        rx_valid = 1'b0;
        restart  = 1'b1;
        tick();
        restart  = 1'b0;
    endtask

    task automatic wait_settle();
        int c;
        c = 0;
        while (!(done === 1'b1 || err === 1'b1) && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) chk1("settle_timeout", done | err, 1'b1);
    endtask

    function automatic bit model_err(input logic [31:0] pc, input int unsigned n);
        return (pc[1:0] != 2'b00) || (n == 0) || (n > MAXW);
    endfunction

    task automatic fill_words(input int unsigned n);
        stim_words.delete();
        for (int i = 0; i < int'(n); i++) stim_words.push_back($urandom);
    endtask

    // Expected writes: word i lands at pc + 4*i (mod 2^32), in stream order.
    task automatic run_load(input bit do_rst, input logic [31:0] pc, input int unsigned n,
                            input bit exp_err, input int gap, input string tag);
        if (do_rst) do_restart();
        wr_q.delete();
        send_header(pc, 16'(n), gap);
        if (!exp_err) begin
            foreach (stim_words[i]) send_word(stim_words[i], gap);
        end
        rx_valid = 1'b0;
        wait_settle();
        chk1({tag, ":err"}, err, exp_err);
        chk1({tag, ":done"}, done, !exp_err);
        chk1({tag, ":cpu_Reset_L"}, cpu_Reset_L, !exp_err);
        chk32({tag, ":nwrites"}, 32'(wr_q.size()), exp_err ? 32'd0 : 32'(n));
        chk32({tag, ":words_loaded"}, 32'(words_loaded), exp_err ? 32'd0 : 32'(n));
        if (exp_err) begin
            chk1({tag, ":rx_ready"}, rx_ready, 1'b0);
        end else begin
            chk32({tag, ":startPC"}, cpu_startPC, pc);
            for (int i = 0; i < int'(n) && i < wr_q.size(); i++) begin
                chk32({tag, ":addr"}, wr_q[i].addr, pc + 32'(4 * i));
                chk32({tag, ":data"}, wr_q[i].data, stim_words[i]);
            end
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        int unsigned n;
        bit          exp_err;
        int          gap;
        bit          fixed;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0040, 2, 1'b0, 0, 1'b1};
        vecs[1] = '{32'h0000_0040, 2, 1'b0, 1, 1'b1};
        vecs[2] = '{32'h0000_0040, 0, 1'b1, 0, 1'b0};
        vecs[3] = '{32'h0000_0042, 2, 1'b1, 0, 1'b0};
        vecs[4] = '{32'h0000_0100, MAXW + 1, 1'b1, 0, 1'b0};
        vecs[5] = '{32'h0000_0100, MAXW, 1'b0, 2, 1'b0};
        vecs[6] = '{32'hFFFF_FFF8, 4, 1'b0, 2, 1'b0};
        vecs[7] = '{32'h0000_1000, 1, 1'b0, 2, 1'b0};

        Reset    = 1'b1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_vals("reset");
        Reset = 1'b0;
        tick();

        // Exact timing: write strobes, hold window and release edge.
        wr_q.delete();
        send_header(32'h0000_0040, 16'd2, 0);
        send_word(32'h2008_0005, 0);
        chk1("w0:we", imem_we, 1'b1);
        chk32("w0:addr", imem_addr, 32'h40);
        chk32("w0:data", imem_wdata, 32'h2008_0005);
        send_byte(8'h20, 0);
        send_byte(8'h09, 0);
        send_byte(8'h00, 0);
        send_byte(8'h07, 0);
        rx_valid = 1'b0;
        chk1("w1:we", imem_we, 1'b1);
        chk1("w1:rx_ready", rx_ready, 1'b0);
        chk32("w1:addr", imem_addr, 32'h44);
        chk32("w1:data", imem_wdata, 32'h2009_0007);
        tick();
        chk1("hold0:we", imem_we, 1'b0);
        chk1("hold0:cpu_Reset_L", cpu_Reset_L, 1'b0);
        chk32("hold0:startPC", cpu_startPC, 32'h40);
        chk1("hold0:done", done, 1'b0);
        tick();
        chk1("hold1:cpu_Reset_L", cpu_Reset_L, 1'b0);
        tick();
        chk1("run:cpu_Reset_L", cpu_Reset_L, 1'b1);
        chk1("run:done", done, 1'b1);
        chk32("run:words_loaded", 32'(words_loaded), 32'd2);
        chk32("run:nwrites", 32'(wr_q.size()), 32'd2);

        foreach (vecs[v]) begin
            if (vecs[v].fixed) stim_words = '{32'h2008_0005, 32'h2009_0007};
            else fill_words(vecs[v].n);
            run_load(1'b1, vecs[v].pc, vecs[v].n, vecs[v].exp_err, vecs[v].gap, "table");
        end

        // From RUN: restart drops done, then a one-word load at address 0.
        do_restart();
        chk1("rerun:done_drop", done, 1'b0);
        chk1("rerun:rst_low", cpu_Reset_L, 1'b0);
        stim_words = '{32'hAC01_0000};
        run_load(1'b0, 32'h0, 1, 1'b0, 0, "rerun");

        // restart after 5 data bytes of a 3-word load: only word 0 is written.
        do_restart();
        wr_q.delete();
        send_header(32'h0000_0200, 16'd3, 0);
        send_word(32'h1111_2222, 0);
        send_byte(8'h33, 0);
        do_restart();
        chk32("abort:nwrites", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) chk32("abort:addr", wr_q[0].addr, 32'h200);
        chk32("abort:words_loaded", 32'(words_loaded), 32'd0);
        chk1("abort:cpu_Reset_L", cpu_Reset_L, 1'b0);
        chk1("abort:done", done, 1'b0);
        chk1("abort:rx_ready", rx_ready, 1'b1);
        fill_words(3);
        run_load(1'b0, 32'h0000_0300, 3, 1'b0, 0, "abort_reload");

        // Reset between edges with the 4th byte of a word pending.
        do_restart();
        wr_q.delete();
        send_header(32'h0000_0080, 16'd2, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hEF;
        #3;
        Reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        tick();
        tick();
        Reset    = 1'b0;
        rx_valid = 1'b0;
        tick();
        chk32("midreset:nwrites", 32'(wr_q.size()), 32'd0);
        fill_words(2);
        run_load(1'b0, 32'h0000_0080, 2, 1'b0, 2, "reset_reload");

        for (int r = 0; r < 6; r++) begin
            logic [31:0] pc;
            int unsigned n;
            pc = $urandom;
            if (r % 3 != 0) pc[1:0] = 2'b00;
            n = $urandom_range(0, MAXW + 1);
            fill_words(n);
            run_load(1'b1, pc, n, model_err(pc, n), 2, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
